dff_pipe: RTL

- Parametrised successor to the single D flip-flop: a chain of DEPTH registered stages, each WIDTH bits wide.
- Each stage carries a valid bit, and the chain uses a valid/ready handshake.
- Bubbles collapse: an empty stage always accepts from upstream, even while the output is stalled.
- Used as a configurable delay line and elastic buffer between datapath blocks. Provides occupancy count and synchronous flush.

---
 rtl/dff_pipe.sv | 94 +++++++++
 1 files changed

// File: rtl/dff_pipe.sv
// Elastic register chain: DEPTH valid/ready stages of WIDTH bits. Empty stages
// always accept from upstream, and the block reports occupancy and supports flush.
module dff_pipe #(
  parameter int unsigned            WIDTH     = 8,
  parameter int unsigned            DEPTH     = 4,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0,
  localparam int unsigned           CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d     [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];
  logic             in_xfer;
  logic             out_xfer;

  // A stage can load when it is empty or when its own item moves on this edge.
  // The ripple runs from the output side, giving the out_ready -> in_ready path.
  always_comb begin : ready_chain
    logic acc;
    // NOTE: combinational logic uses blocking '=' so acc carries each stage's
    // result into the next loop iteration; clocked state below uses '<=' only.
    acc = out_ready;
    rdy = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc    = !v[i] | acc;
      rdy[i] = acc;
    end
  end

  always_comb begin : stage_sources
    src_v[0] = in_valid;
    src_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = v[i-1];
      src_d[i] = d[i-1];
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = v[DEPTH-1] & ~flush;
  assign out_data  = d[DEPTH-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) v[i] <= src_v[i];
      end
    end
  end

  // NOTE: the data registers are deliberately reset so out_data shows RESET_VAL
  // during reset; they only load when a valid item arrives, and flush leaves them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) d[i] <= RESET_VAL;
    end else if (!flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i] && src_v[i]) d[i] <= src_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (in_xfer && !out_xfer) begin
      count <= count + CW'(1);
    end else if (!in_xfer && out_xfer) begin
      count <= count - CW'(1);
    end
  end

endmodule
